// File: rtl/imm_decode_stage.sv
// Decode-stage controller: classifies fetched opcodes into immediate-type codes and
// holds them in a head + skid buffer in front of execute. Optional macro: ILLEGAL_TRAP_EN.
module imm_decode_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   flush_in,
  input  logic                   in_valid_in,
  output logic                   in_ready_out,
  input  logic [31:0]            instr_in,
  input  logic [XLEN-1:0]        pc_in,
  output logic                   out_valid_out,
  input  logic                   out_ready_in,
  output logic [24:0]            instr_out,
  output logic [XLEN-1:0]        pc_out,
  output logic [2:0]             imm_type_out,
  output logic [STALL_CNT_W-1:0] stall_cnt_out
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                   illegal_out
`endif
);

  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;
  localparam logic [2:0] IMM_S = 3'b110;

  function automatic logic [2:0] decode_imm_type(input logic [6:0] opcode);
    case (opcode)
      7'b0110011:                                     decode_imm_type = IMM_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: decode_imm_type = IMM_I;
      7'b0100011:                                     decode_imm_type = IMM_S;
      7'b1100011:                                     decode_imm_type = IMM_B;
      7'b0110111, 7'b0010111:                         decode_imm_type = IMM_U;
      7'b1101111:                                     decode_imm_type = IMM_J;
      default:                                        decode_imm_type = IMM_I;
    endcase
  endfunction

  logic                   head_valid_q, head_valid_d;
  logic [24:0]            head_instr_q, head_instr_d;
  logic [XLEN-1:0]        head_pc_q,    head_pc_d;
  logic [2:0]             head_type_q,  head_type_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [24:0]            skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]        skid_pc_q,    skid_pc_d;
  logic [2:0]             skid_type_q,  skid_type_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

  logic       accept;
  logic       pop;
  logic       load_head_new;
  logic       load_head_skid;
  logic       load_skid;
  logic [2:0] dec_type;

  assign dec_type = decode_imm_type(instr_in[6:0]);

  // Flush outranks both handshakes: nothing enters and nothing is counted as consumed.
  assign accept         = in_valid_in & ~skid_valid_q & ~flush_in;
  assign pop            = head_valid_q & out_ready_in & ~flush_in;
  assign load_head_skid = pop & skid_valid_q;
  assign load_head_new  = accept & (~head_valid_q | (pop & ~skid_valid_q));
  assign load_skid      = accept & head_valid_q & ~pop;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    head_valid_d = head_valid_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    head_type_d  = head_type_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_type_d  = skid_type_q;

    if (flush_in) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (load_head_skid) begin
        head_valid_d = 1'b1;
        head_instr_d = skid_instr_q;
        head_pc_d    = skid_pc_q;
        head_type_d  = skid_type_q;
        skid_valid_d = 1'b0;
      end else if (load_head_new) begin
        head_valid_d = 1'b1;
        head_instr_d = instr_in[31:7];
        head_pc_d    = pc_in;
        head_type_d  = dec_type;
      end else if (pop) begin
        head_valid_d = 1'b0;
      end

      if (load_skid) begin
        skid_valid_d = 1'b1;
        skid_instr_d = instr_in[31:7];
        skid_pc_d    = pc_in;
        skid_type_d  = dec_type;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (head_valid_q && !out_ready_in && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // NOTE: the buffer entries are a handful of flops and feed visible outputs with
  // defined reset values, so they are reset like any control register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_valid_q <= 1'b0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      head_type_q  <= IMM_R;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_type_q  <= IMM_R;
      stall_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      head_valid_q <= head_valid_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      head_type_q  <= head_type_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_type_q  <= skid_type_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign in_ready_out  = ~skid_valid_q;
  assign out_valid_out = head_valid_q;
  assign instr_out     = head_instr_q;
  assign pc_out        = head_pc_q;
  assign imm_type_out  = head_type_q;
  assign stall_cnt_out = stall_cnt_q;

`ifdef ILLEGAL_TRAP_EN
  function automatic logic is_known_opcode(input logic [6:0] opcode);
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111:
        is_known_opcode = 1'b1;
      default:
        is_known_opcode = 1'b0;
    endcase
  endfunction

  logic head_ill_q, head_ill_d;
  logic skid_ill_q, skid_ill_d;
  logic dec_ill;

  assign dec_ill = ~is_known_opcode(instr_in[6:0]);

  // The illegal flag rides with its entry but, unlike the data fields, a flush clears it.
  always_comb begin
    head_ill_d = head_ill_q;
    skid_ill_d = skid_ill_q;
    if (flush_in) begin
      head_ill_d = 1'b0;
      skid_ill_d = 1'b0;
    end else begin
      if (load_head_skid) begin
        head_ill_d = skid_ill_q;
      end else if (load_head_new) begin
        head_ill_d = dec_ill;
      end
      if (load_skid) begin
        skid_ill_d = dec_ill;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_ill_q <= 1'b0;
      skid_ill_q <= 1'b0;
    end else begin
      head_ill_q <= head_ill_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign illegal_out = head_ill_q;
`endif

endmodule
